// File: rtl/vga_pkg.sv
// +------------------------------------------------------------------+
// | Module      : vga_pkg                                              |
// | Description : Default 640x480@60 timing constants, derived totals  |
// |               and sync positions, and the scan flag bundle type.   |
// | Revision    : 1.0                                                  |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package vga_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int HT_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int VT_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
    localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

    localparam int CNT_W = 10;

    // Raw decode flags, all active-high; travel together down the pipeline.
    typedef struct packed {
        logic visible;
        logic hsync;
        logic vsync;
    } scan_flags_t;

endpackage

`default_nettype wire

// File: rtl/vga_hv_counter.sv
// +------------------------------------------------------------------+
// | Module      : vga_hv_counter                                       |
// | Description : Horizontal/vertical scan counters with wrap logic    |
// |               and raw visible / hsync / vsync decode.              |
// | Revision    : 1.0                                                  |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module vga_hv_counter
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic             vga_clk,
    input  logic             clrn,
    output logic [9:0]       col_addr,
    output logic [8:0]       row_addr,
    output scan_flags_t      flags,
    output logic             frame_end
);

    localparam int HT      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_BEG  = H_VISIBLE + H_FRONT;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_VISIBLE + V_FRONT;
    localparam int VS_END  = VS_BEG + V_SYNC;

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             w_h_last;
    logic             w_v_last;

    assign w_h_last = (r_h_cnt == CNT_W'(HT - 1));
    assign w_v_last = (r_v_cnt == CNT_W'(VT - 1));

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign col_addr = r_h_cnt;
    assign row_addr = r_v_cnt[8:0];

    assign flags.visible = (r_h_cnt < CNT_W'(H_VISIBLE)) && (r_v_cnt < CNT_W'(V_VISIBLE));
    assign flags.hsync   = (r_h_cnt >= CNT_W'(HS_BEG)) && (r_h_cnt < CNT_W'(HS_END));
    assign flags.vsync   = (r_v_cnt >= CNT_W'(VS_BEG)) && (r_v_cnt < CNT_W'(VS_END));
    assign frame_end     = w_h_last && w_v_last;

endmodule

`default_nettype wire

// File: rtl/vga_scan_ctrl.sv
// +------------------------------------------------------------------+
// | Module      : vga_scan_ctrl                                        |
// | Description : VGA scan controller: address generation, 2-stage     |
// |               pixel/sync pipeline, blanking and frame_start pulse. |
// |               Define VGA_FRAME_CNT_EN to add the frame_cnt output. |
// | Revision    : 1.0                                                  |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic        vga_clk,
    input  logic        clrn,
    input  logic [11:0] d_in_BGR,
    output logic [9:0]  col_addr,
    output logic [8:0]  row_addr,
    output logic        rdn,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        hs,
    output logic        vs,
    output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    scan_flags_t w_flags;
    logic        w_frame_end;

    scan_flags_t r_flags_d1;
    logic [3:0]  r_r;
    logic [3:0]  r_g;
    logic [3:0]  r_b;
    logic        r_hs;
    logic        r_vs;
    logic        r_frame_start;

    vga_hv_counter #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_hv_counter (
        .vga_clk   (vga_clk),
        .clrn      (clrn),
        .col_addr  (col_addr),
        .row_addr  (row_addr),
        .flags     (w_flags),
        .frame_end (w_frame_end)
    );

    assign rdn = ~w_flags.visible;

    // Stage 1 aligns flags with the returning pixel; stage 2 registers the
    // blanked colour. The explicit if keeps unknown blanking data off r/g/b.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_flags_d1    <= '0;
            r_r           <= '0;
            r_g           <= '0;
            r_b           <= '0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_flags_d1    <= w_flags;
            r_hs          <= ~r_flags_d1.hsync;
            r_vs          <= ~r_flags_d1.vsync;
            r_frame_start <= w_frame_end;
            if (r_flags_d1.visible) begin
                r_r <= d_in_BGR[3:0];
                r_g <= d_in_BGR[7:4];
                r_b <= d_in_BGR[11:8];
            end else begin
                r_r <= '0;
                r_g <= '0;
                r_b <= '0;
            end
        end
    end

    assign r           = r_r;
    assign g           = r_g;
    assign b           = r_b;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign frame_start = r_frame_start;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_frame_cnt <= '0;
        end else if (r_frame_start) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
// +------------------------------------------------------------------+
// | Module      : tb_vga_scan_ctrl                                     |
// | Description : Self-checking bench for vga_scan_ctrl (directed      |
// |               vector table plus timing/reset sequences).           |
// | Revision    : 1.0                                                  |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_vga_scan_ctrl;

    // Vertical timing shrunk so several frames fit in a short run:
    // 8 visible rows, vsync on rows 10..11, 15 lines per frame.
    localparam int HT_CLKS    = 800;
    localparam int FRAME_CLKS = 800 * 15;

    logic        vga_clk;
    logic        clrn;
    logic [11:0] d_in_BGR;
    logic [9:0]  col_addr;
    logic [8:0]  row_addr;
    logic        rdn;
    logic [3:0]  r, g, b;
    logic        hs, vs;
    logic        frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    vga_scan_ctrl #(
        .V_VISIBLE (8),
        .V_FRONT   (2),
        .V_SYNC    (2),
        .V_BACK    (3)
    ) dut (
        .vga_clk     (vga_clk),
        .clrn        (clrn),
        .d_in_BGR    (d_in_BGR),
        .col_addr    (col_addr),
        .row_addr    (row_addr),
        .rdn         (rdn),
        .r           (r),
        .g           (g),
        .b           (b),
        .hs          (hs),
        .vs          (vs),
        .frame_start (frame_start)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    // Pixel source: returns {2'b0,col} one clock after the address, X when blank.
    initial begin
        logic [9:0] p_col;
        logic       p_rdn;
        d_in_BGR = 12'h000;
        forever begin
            @(negedge vga_clk);
            p_col = col_addr;
            p_rdn = rdn;
            @(posedge vga_clk);
            #1;
            d_in_BGR = p_rdn ? 12'bx : {2'b00, p_col};
        end
    end

    typedef struct {
        int         col;
        int         row;
        logic       rdn;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting, got none expected event", name);
    endtask

    task automatic goto(input int col, input int row);
        int n;
        n = 0;
        while (!(32'(col_addr) == col && 32'(row_addr) == row) && n < 2 * FRAME_CLKS) begin
            @(negedge vga_clk);
            n++;
        end
        if (n >= 2 * FRAME_CLKS) timeout($sformatf("goto(%0d,%0d)", col, row));
    endtask

    initial begin
        int n;

        //          col  row rdn   r     g     b    hs    vs
        vecs[0]  = '{  0,  0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1};
        vecs[1]  = '{  5,  0, 1'b0, 4'h5, 4'h0, 4'h0, 1'b1, 1'b1};
        vecs[2]  = '{300,  1, 1'b0, 4'hC, 4'h2, 4'h1, 1'b1, 1'b1};
        vecs[3]  = '{639,  1, 1'b0, 4'hF, 4'h7, 4'h2, 1'b1, 1'b1};
        vecs[4]  = '{640,  2, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1};
        vecs[5]  = '{655,  2, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1};
        vecs[6]  = '{656,  3, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[7]  = '{751,  3, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[8]  = '{752,  4, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1};
        vecs[9]  = '{123,  7, 1'b0, 4'hB, 4'h7, 4'h0, 1'b1, 1'b1};
        vecs[10] = '{123,  8, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1};
        vecs[11] = '{  5, 10, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[12] = '{700, 11, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[13] = '{  5, 12, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1};
        vecs[14] = '{799, 14, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1};

        // Reset state.
        clrn = 1'b0;
        repeat (4) @(negedge vga_clk);
        chk("rst_col", 32'(col_addr), 32'd0);
        chk("rst_row", 32'(row_addr), 32'd0);
        chk("rst_rdn", 32'(rdn), 32'd0);
        chk("rst_rgb", 32'({r, g, b}), 32'd0);
        chk("rst_hs_vs", 32'({hs, vs}), 32'd3);
        chk("rst_frame_start", 32'(frame_start), 32'd0);

        // Release between edges and watch the scan start.
        clrn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("release_col%0d", k), 32'(col_addr), 32'(k));
            chk($sformatf("release_hs_vs%0d", k), 32'({hs, vs}), 32'd3);
            if (k < 2) @(negedge vga_clk);
        end
        chk("release_rdn", 32'(rdn), 32'd0);

        // First frame_start comes only at the first wrap back to (0,0).
        n = 2;
        while (frame_start !== 1'b1 && n < FRAME_CLKS + 1000) begin
            @(negedge vga_clk);
            n++;
        end
        chk("first_frame_start_delay", 32'(n), 32'(FRAME_CLKS));
        chk("frame_start_pos", 32'({col_addr, row_addr}), 32'd0);

        // Table-driven pixel/sync alignment through frame 2.
        for (int i = 0; i < 15; i++) begin
            goto(vecs[i].col, vecs[i].row);
            chk($sformatf("rdn[%0d]", i), 32'(rdn), 32'(vecs[i].rdn));
            repeat (2) @(negedge vga_clk);
            chk($sformatf("rgb[%0d]", i), 32'({r, g, b}), 32'({vecs[i].r, vecs[i].g, vecs[i].b}));
            chk($sformatf("hs[%0d]", i), 32'(hs), 32'(vecs[i].hs));
            chk($sformatf("vs[%0d]", i), 32'(vs), 32'(vecs[i].vs));
        end

        // Line timing: hs falls 658 clocks after col 0, low 96, period 800.
        n = 0;
        while (col_addr !== 10'd0 && n < 2 * HT_CLKS) begin
            @(negedge vga_clk);
            n++;
        end
        n = 0;
        while (hs !== 1'b0 && n < 2 * HT_CLKS) begin
            @(negedge vga_clk);
            n++;
        end
        chk("hs_fall_offset", 32'(n), 32'd658);
        n = 0;
        while (hs === 1'b0 && n < 2 * HT_CLKS) begin
            @(negedge vga_clk);
            n++;
        end
        chk("hs_low_width", 32'(n), 32'd96);
        while (hs !== 1'b0 && n < 2 * HT_CLKS) begin
            @(negedge vga_clk);
            n++;
        end
        chk("hs_period", 32'(n), 32'(HT_CLKS));

        // Frame timing: vs low for two lines, frame_start once per frame.
        n = 0;
        while (vs !== 1'b0 && n < 2 * FRAME_CLKS) begin
            @(negedge vga_clk);
            n++;
        end
        n = 0;
        while (vs === 1'b0 && n < 2 * FRAME_CLKS) begin
            @(negedge vga_clk);
            n++;
        end
        chk("vs_low_width", 32'(n), 32'd1600);

        n = 0;
        while (frame_start !== 1'b1 && n < 2 * FRAME_CLKS) begin
            @(negedge vga_clk);
            n++;
        end
        if (n >= 2 * FRAME_CLKS) timeout("frame_start_wait");
        @(negedge vga_clk);
        chk("frame_start_one_cycle", 32'(frame_start), 32'd0);
        n = 1;
        while (frame_start !== 1'b1 && n < 2 * FRAME_CLKS) begin
            @(negedge vga_clk);
            n++;
        end
        chk("frame_start_period", 32'(n), 32'(FRAME_CLKS));

        // Asynchronous reset mid-line, applied between clock edges.
        goto(300, 2);
        chk("pre_reset_rgb", 32'({r, g, b}), 32'({4'hA, 4'h2, 4'h1}));
        #1;
        clrn = 1'b0;
        #1;
        chk("async_col", 32'(col_addr), 32'd0);
        chk("async_row", 32'(row_addr), 32'd0);
        chk("async_rdn", 32'(rdn), 32'd0);
        chk("async_rgb", 32'({r, g, b}), 32'd0);
        chk("async_hs_vs", 32'({hs, vs}), 32'd3);
        chk("async_frame_start", 32'(frame_start), 32'd0);
        repeat (3) @(negedge vga_clk);
        clrn = 1'b1;
        chk("restart_pos0", 32'({col_addr, row_addr}), 32'd0);
`ifdef VGA_FRAME_CNT_EN
        chk("frame_cnt_reset", 32'(frame_cnt), 32'd0);
`endif
        @(negedge vga_clk);
        chk("restart_col1", 32'(col_addr), 32'd1);
        chk("restart_row0", 32'(row_addr), 32'd0);
`ifdef VGA_FRAME_CNT_EN
        // Last clock of the third frame: two frame_start pulses counted.
        repeat (3 * FRAME_CLKS - 2) @(negedge vga_clk);
        chk("frame_cnt_3frames", 32'(frame_cnt), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_scan_ctrl.md
VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, meaning horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96, meaning hsync pulse width in clocks.
REQ-004 SHALL have parameter H_BACK, default 48, meaning horizontal back porch in clocks.
REQ-005 SHALL have parameters V_VISIBLE 480, V_FRONT 10, V_SYNC 2, V_BACK 33, meaning the vertical equivalents in lines.
REQ-006 SHALL have port vga_clk  input  1  pixel clock; the only clock.
REQ-007 SHALL have port clrn  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port d_in_BGR  input  12  pixel colour {B,G,R}, 4 bits each, from the pixel source.
REQ-009 SHALL have port col_addr  output  10  current horizontal scan position.
REQ-010 SHALL have port row_addr  output  9  current vertical scan position, low 9 bits.
REQ-011 SHALL have port rdn  output  1  active-low: current address is visible.
REQ-012 SHALL have ports r, g, b  output  4 each  registered, blanked colour to the DAC.
REQ-013 SHALL have ports hs, vs  output  1 each  active-low sync, aligned to r/g/b.
REQ-014 SHALL have port frame_start  output  1  one-cycle pulse at the start of a frame.

Function
REQ-015 SHALL keep h_cnt 0..HT-1 (HT = sum of H params, 800); increment every clock; wrap HT-1 -> 0.
REQ-016 SHALL keep v_cnt 0..VT-1 (VT = 525); increment only when h_cnt wraps; wrap VT-1 -> 0 on the same edge that h_cnt wraps.
REQ-017 SHALL drive col_addr = h_cnt and row_addr = v_cnt[8:0] directly from the counter registers.
REQ-018 SHALL drive rdn low only when h_cnt < H_VISIBLE and v_cnt < V_VISIBLE, same cycle as the address.
REQ-019 SHALL treat hsync as active when H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751); vsync uses 490..491 on v_cnt.
REQ-020 SHALL sample d_in_BGR one clock after the address it belongs to; r/g/b, hs and vs SHALL appear two clocks after the address (address at t, pixel at t+1, outputs at t+2).
REQ-021 SHALL delay the visible flag, hsync and vsync through the same 2-stage pipeline; r/g/b SHALL be 0 when the delayed visible flag is low.
REQ-022 SHALL map r = d_in_BGR[3:0], g = [7:4], b = [11:8].
REQ-023 SHALL pulse frame_start high for exactly one clock, on the cycle the counters read (0,0) after a wrap from (HT-1,VT-1); frame_start SHALL NOT pulse for the first frame after reset.
REQ-024 SHALL ignore d_in_BGR during blanking; X or Z on d_in_BGR during blanking SHALL NOT reach r/g/b.

Reset
REQ-025 SHALL, while clrn is low, force h_cnt=0, v_cnt=0, rdn=0, r=g=b=0, hs=vs=1, frame_start=0, and clear all pipeline flags.
REQ-026 SHALL, on clrn asserted mid-frame, take reset values at once without waiting for a clock; scanning SHALL restart at (0,0) on the first edge after release.

Configuration
REQ-027 SHALL, when VGA_FRAME_CNT_EN is defined, add output frame_cnt (16 bits); it resets to 0, increments when frame_start is high, and wraps 65535 -> 0.
REQ-028 SHALL, when VGA_FRAME_CNT_EN is undefined, omit the frame_cnt port and its logic; all other behaviour is unchanged.

Structure
REQ-029 SHALL put the default timing constants, and derived HT/VT and sync start/end positions, in shared package vga_pkg.
REQ-030 SHALL contain one sub-module, vga_hv_counter, that holds h_cnt/v_cnt, the wrap logic and the raw visible/hsync/vsync decode; vga_scan_ctrl holds the pipeline, blanking and frame_start.

Verification
REQ-031 SHALL check reset release: clrn 0->1 -> col_addr 0,1,2... on successive clocks; rdn=0; hs=vs=1 for the first 2 clocks.
REQ-032 SHALL check line timing: count clocks -> hs low 96 clocks, starting 658 clocks after col_addr=0 (656 + 2-cycle latency); period 800 clocks.
REQ-033 SHALL check frame timing: vs low for 2 lines (1600 clocks); frame_start pulses every 420000 clocks; none in the first frame.
REQ-034 SHALL check pixel alignment: d_in_BGR = {2'b0,col_addr} one cycle late -> r/g/b at t+2 match the col_addr from t; r/g/b = 0 for col 640..799 and rows 480..524.
REQ-035 SHALL check async reset mid-line: clrn low at col 300 row 100 between edges -> outputs at reset values before the next edge; restart at (0,0).
REQ-036 SHALL check frame_cnt with VGA_FRAME_CNT_EN: run 3 frames -> frame_cnt=2; preload near wrap -> 65535 -> 0.
